// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: register-number width,
// forwarding select codes and controller FSM states.
package pipe_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] reg_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN,
    ST_MWAIT
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage register info, the
// data-memory handshake, and the per-stage freeze/bubble/flush/forward controls.
interface pipe_hazard_ctrl_if;

  pipe_pkg::reg_t i_dec_rs;
  pipe_pkg::reg_t i_dec_rt;
  logic           i_dec_rs_use;
  logic           i_dec_rt_use;
  logic           i_dec_br_taken;
  pipe_pkg::reg_t i_exe_wra;
  logic           i_exe_regwe;
  logic           i_exe_isload;
  pipe_pkg::reg_t i_mem_wra;
  logic           i_mem_regwe;
  logic           i_mem_req;
  logic           i_dmem_ready;

  logic           o_freeze_ftc;
  logic           o_freeze_dec;
  logic           o_freeze_exe;
  logic           o_freeze_mem;
  logic           o_bubble_exe;
  logic           o_bubble_wrt;
  logic           o_flush_dec;
  logic [1:0]     o_fwd_a;
  logic [1:0]     o_fwd_b;

  modport master (
    output i_dec_rs, i_dec_rt, i_dec_rs_use, i_dec_rt_use, i_dec_br_taken,
    output i_exe_wra, i_exe_regwe, i_exe_isload, i_mem_wra, i_mem_regwe,
    output i_mem_req, i_dmem_ready,
    input  o_freeze_ftc, o_freeze_dec, o_freeze_exe, o_freeze_mem,
    input  o_bubble_exe, o_bubble_wrt, o_flush_dec, o_fwd_a, o_fwd_b
  );

  modport slave (
    input  i_dec_rs, i_dec_rt, i_dec_rs_use, i_dec_rt_use, i_dec_br_taken,
    input  i_exe_wra, i_exe_regwe, i_exe_isload, i_mem_wra, i_mem_regwe,
    input  i_mem_req, i_dmem_ready,
    output o_freeze_ftc, o_freeze_dec, o_freeze_exe, o_freeze_mem,
    output o_bubble_exe, o_bubble_wrt, o_flush_dec, o_fwd_a, o_fwd_b
  );

endinterface

// File: rtl/hazard_match.sv
// One source-vs-destination comparator; register 0 never matches.
module hazard_match
  import pipe_pkg::*;
(
  input  reg_t src_i,
  input  logic use_i,
  input  logic we_i,
  input  reg_t wra_i,
  output logic hit_o
);

  assign hit_o = (src_i != '0) & use_i & we_i & (src_i == wra_i);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the FTC/DEC/EXE/MEM/WRT pipeline.
// Define PIPE_HAZARD_FWD_EN to enable operand forwarding; otherwise every RAW hazard stalls.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned TMO_CYCLES  = 255,
  parameter int unsigned STALL_CNT_W = 32,
  parameter int unsigned FLUSH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pipe_hazard_ctrl_if.slave      hz,
  output logic [STALL_CNT_W-1:0] o_stall_cnt,
  output logic [FLUSH_CNT_W-1:0] o_flush_cnt,
  output logic                   o_mem_timeout
);

  localparam logic [7:0] TmoLast = 8'(TMO_CYCLES - 1);

  state_e                 state_q;
  logic [7:0]             wait_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q;
  logic                   tmo_q;

  logic hit_exe_a, hit_exe_b, hit_mem_a, hit_mem_b;
  logic mem_wait, stall, flush;
  logic [1:0] fwd_a, fwd_b;

  hazard_match u_exe_a (
    .src_i(hz.i_dec_rs), .use_i(hz.i_dec_rs_use), .we_i(hz.i_exe_regwe),
    .wra_i(hz.i_exe_wra), .hit_o(hit_exe_a)
  );
  hazard_match u_exe_b (
    .src_i(hz.i_dec_rt), .use_i(hz.i_dec_rt_use), .we_i(hz.i_exe_regwe),
    .wra_i(hz.i_exe_wra), .hit_o(hit_exe_b)
  );
  hazard_match u_mem_a (
    .src_i(hz.i_dec_rs), .use_i(hz.i_dec_rs_use), .we_i(hz.i_mem_regwe),
    .wra_i(hz.i_mem_wra), .hit_o(hit_mem_a)
  );
  hazard_match u_mem_b (
    .src_i(hz.i_dec_rt), .use_i(hz.i_dec_rt_use), .we_i(hz.i_mem_regwe),
    .wra_i(hz.i_mem_wra), .hit_o(hit_mem_b)
  );

`ifndef PIPE_HAZARD_FWD_EN
  logic unused_isload;
  assign unused_isload = hz.i_exe_isload;
`endif

  always_comb begin
    mem_wait = (state_q == ST_MWAIT) ? ~hz.i_dmem_ready : (hz.i_mem_req & ~hz.i_dmem_ready);
`ifdef PIPE_HAZARD_FWD_EN
    stall = hz.i_exe_isload & (hit_exe_a | hit_exe_b);
    fwd_a = (hit_exe_a & ~hz.i_exe_isload) ? FWD_EXE : (hit_mem_a ? FWD_MEM : FWD_REG);
    fwd_b = (hit_exe_b & ~hz.i_exe_isload) ? FWD_EXE : (hit_mem_b ? FWD_MEM : FWD_REG);
`else
    // Without bypass paths, hold DEC until the producer has reached WRT.
    stall = hit_exe_a | hit_exe_b | hit_mem_a | hit_mem_b;
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
`endif
    flush = ~mem_wait & ~stall & hz.i_dec_br_taken;

    hz.o_freeze_ftc = ~rst & (mem_wait | stall);
    hz.o_freeze_dec = ~rst & (mem_wait | stall);
    hz.o_freeze_exe = ~rst & mem_wait;
    hz.o_freeze_mem = ~rst & mem_wait;
    hz.o_bubble_wrt = ~rst & mem_wait;
    hz.o_bubble_exe = ~rst & ~mem_wait & stall;
    hz.o_flush_dec  = ~rst & flush;
    hz.o_fwd_a      = rst ? FWD_REG : fwd_a;
    hz.o_fwd_b      = rst ? FWD_REG : fwd_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q <= mem_wait ? ST_MWAIT : ST_RUN;
      if (!mem_wait) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != 8'hff) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
      // The access is never abandoned; the flag only reports it.
      if (mem_wait && wait_cnt_q == TmoLast) begin
        tmo_q <= 1'b1;
      end
      if ((mem_wait || stall) && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
      if (flush && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + FLUSH_CNT_W'(1);
      end
    end
  end

  assign o_stall_cnt   = stall_cnt_q;
  assign o_flush_cnt   = flush_cnt_q;
  assign o_mem_timeout = tmo_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// cycles against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        tmo;
  int          total = 0;
  int          bad = 0;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .hz           (hz),
    .o_stall_cnt  (stall_cnt),
    .o_flush_cnt  (flush_cnt),
    .o_mem_timeout(tmo)
  );

  always #5 clk = ~clk;

  // {frz_ftc, frz_dec, frz_exe, frz_mem, bub_exe, bub_wrt, flush_dec, fwd_a, fwd_b}
  logic [10:0] ctl;
  assign ctl = {hz.o_freeze_ftc, hz.o_freeze_dec, hz.o_freeze_exe, hz.o_freeze_mem,
                hz.o_bubble_exe, hz.o_bubble_wrt, hz.o_flush_dec, hz.o_fwd_a, hz.o_fwd_b};

  localparam logic [10:0] C_IDLE = 11'b0000_000_00_00;
  localparam logic [10:0] C_LU   = 11'b1100_100_00_00;
  localparam logic [10:0] C_MW   = 11'b1111_010_00_00;
  localparam logic [10:0] C_FL   = 11'b0000_001_00_00;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    hz.i_dec_rs = '0; hz.i_dec_rt = '0; hz.i_dec_rs_use = 0; hz.i_dec_rt_use = 0;
    hz.i_dec_br_taken = 0; hz.i_exe_wra = '0; hz.i_exe_regwe = 0; hz.i_exe_isload = 0;
    hz.i_mem_wra = '0; hz.i_mem_regwe = 0; hz.i_mem_req = 0; hz.i_dmem_ready = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  function automatic bit hits(logic [4:0] s, logic u, logic we, logic [4:0] w);
    return (s != 5'd0) && u && we && (s == w);
  endfunction

  // Expected controls from the priority rules: memory wait, then RAW stall, then branch.
  function automatic logic [10:0] model_ctl(bit busy);
    bit waiting, lu, ea, eb, ma, mb;
    logic [1:0] fa, fb;
    waiting = busy ? !hz.i_dmem_ready : (hz.i_mem_req && !hz.i_dmem_ready);
    ea = hits(hz.i_dec_rs, hz.i_dec_rs_use, hz.i_exe_regwe, hz.i_exe_wra);
    eb = hits(hz.i_dec_rt, hz.i_dec_rt_use, hz.i_exe_regwe, hz.i_exe_wra);
    ma = hits(hz.i_dec_rs, hz.i_dec_rs_use, hz.i_mem_regwe, hz.i_mem_wra);
    mb = hits(hz.i_dec_rt, hz.i_dec_rt_use, hz.i_mem_regwe, hz.i_mem_wra);
`ifdef PIPE_HAZARD_FWD_EN
    lu = hz.i_exe_isload && (ea || eb);
    fa = (ea && !hz.i_exe_isload) ? 2'b01 : (ma ? 2'b10 : 2'b00);
    fb = (eb && !hz.i_exe_isload) ? 2'b01 : (mb ? 2'b10 : 2'b00);
`else
    lu = ea || eb || ma || mb;
    fa = 2'b00;
    fb = 2'b00;
`endif
    if (waiting) return {7'b1111_010, fa, fb};
    if (lu) return {7'b1100_100, fa, fb};
    return {6'b0000_00, hz.i_dec_br_taken, fa, fb};
  endfunction

  task automatic test_reset();
    clear_in();
    rst = 1'b1;
    hz.i_mem_req = 1; hz.i_dec_br_taken = 1;
    hz.i_exe_wra = 5'd2; hz.i_exe_regwe = 1; hz.i_exe_isload = 1;
    hz.i_dec_rs = 5'd2; hz.i_dec_rs_use = 1;
    @(negedge clk);
    total++;
    if (ctl !== C_IDLE) begin bad++; $display("FAIL rst_ctl got=%b want=%b", ctl, C_IDLE); end
    cyc();
    cyc();
    clear_in();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({stall_cnt, flush_cnt, tmo} !== 49'd0) begin
      bad++; $display("FAIL rst_state got=%0d/%0d/%b want=0/0/0", stall_cnt, flush_cnt, tmo);
    end
    total++;
    if (ctl !== C_IDLE) begin bad++; $display("FAIL rst_idle got=%b want=%b", ctl, C_IDLE); end
  endtask

  task automatic test_load_use();
    logic [10:0] want;
    do_reset();
    hz.i_exe_wra = 5'd2; hz.i_exe_regwe = 1; hz.i_exe_isload = 1;
    hz.i_dec_rs = 5'd2; hz.i_dec_rs_use = 1;
    @(negedge clk);
    total++;
    if (ctl !== C_LU) begin bad++; $display("FAIL lu_stall got=%b want=%b", ctl, C_LU); end
    cyc();
    hz.i_exe_regwe = 0; hz.i_exe_isload = 0; hz.i_exe_wra = '0;
    hz.i_mem_wra = 5'd2; hz.i_mem_regwe = 1;
`ifdef PIPE_HAZARD_FWD_EN
    want = 11'b0000_000_10_00;
`else
    want = C_LU;
`endif
    @(negedge clk);
    total++;
    if (ctl !== want) begin bad++; $display("FAIL lu_next got=%b want=%b", ctl, want); end
    total++;
    if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", stall_cnt); end
  endtask

  task automatic test_forward();
    logic [10:0] want;
    do_reset();
    hz.i_exe_wra = 5'd3; hz.i_exe_regwe = 1;
    hz.i_mem_wra = 5'd3; hz.i_mem_regwe = 1;
    hz.i_dec_rt = 5'd3; hz.i_dec_rt_use = 1; hz.i_dec_rs = 5'd7; hz.i_dec_rs_use = 1;
`ifdef PIPE_HAZARD_FWD_EN
    want = 11'b0000_000_00_01;
`else
    want = C_LU;
`endif
    @(negedge clk);
    total++;
    if (ctl !== want) begin bad++; $display("FAIL fwd_exe got=%b want=%b", ctl, want); end
    hz.i_exe_wra = 5'd4;
`ifdef PIPE_HAZARD_FWD_EN
    want = 11'b0000_000_00_10;
`endif
    #1;
    total++;
    if (ctl !== want) begin bad++; $display("FAIL fwd_mem got=%b want=%b", ctl, want); end
    cyc();
    clear_in();
    hz.i_dec_rs = 5'd0; hz.i_dec_rs_use = 1; hz.i_dec_rt = 5'd0; hz.i_dec_rt_use = 1;
    hz.i_exe_wra = 5'd0; hz.i_exe_regwe = 1; hz.i_exe_isload = 1;
    hz.i_mem_wra = 5'd0; hz.i_mem_regwe = 1;
    @(negedge clk);
    total++;
    if (ctl !== C_IDLE) begin bad++; $display("FAIL fwd_r0 got=%b want=%b", ctl, C_IDLE); end
  endtask

  task automatic test_branch();
    logic [10:0] want;
    do_reset();
    hz.i_dec_br_taken = 1;
    @(negedge clk);
    total++;
    if (ctl !== C_FL) begin bad++; $display("FAIL br_flush got=%b want=%b", ctl, C_FL); end
    cyc();
    total++;
    if (flush_cnt !== 16'd1) begin bad++; $display("FAIL br_cnt got=%0d want=1", flush_cnt); end
    hz.i_exe_wra = 5'd5; hz.i_exe_regwe = 1; hz.i_exe_isload = 1;
    hz.i_dec_rs = 5'd5; hz.i_dec_rs_use = 1;
    @(negedge clk);
    total++;
    if (ctl !== C_LU) begin bad++; $display("FAIL br_in_stall got=%b want=%b", ctl, C_LU); end
    cyc();
    hz.i_exe_regwe = 0; hz.i_exe_isload = 0; hz.i_exe_wra = '0;
    hz.i_mem_wra = 5'd5; hz.i_mem_regwe = 1;
`ifdef PIPE_HAZARD_FWD_EN
    want = 11'b0000_001_10_00;
`else
    want = C_LU;
`endif
    @(negedge clk);
    total++;
    if (ctl !== want) begin bad++; $display("FAIL br_after got=%b want=%b", ctl, want); end
    cyc();
`ifndef PIPE_HAZARD_FWD_EN
    hz.i_mem_regwe = 0;
    @(negedge clk);
    total++;
    if (ctl !== C_FL) begin bad++; $display("FAIL br_wrt got=%b want=%b", ctl, C_FL); end
    cyc();
`endif
    total++;
    if (flush_cnt !== 16'd2) begin bad++; $display("FAIL br_cnt2 got=%0d want=2", flush_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    hz.i_mem_req = 1; hz.i_dmem_ready = 0; hz.i_dec_br_taken = 1;
    hz.i_exe_wra = 5'd2; hz.i_exe_regwe = 1; hz.i_exe_isload = 1;
    hz.i_dec_rs = 5'd2; hz.i_dec_rs_use = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (ctl !== C_MW) begin bad++; $display("FAIL mw_c%0d got=%b want=%b", i, ctl, C_MW); end
      cyc();
    end
    clear_in();
    hz.i_mem_req = 1; hz.i_dmem_ready = 1;
    @(negedge clk);
    total++;
    if (ctl !== C_IDLE) begin bad++; $display("FAIL mw_ready got=%b want=%b", ctl, C_IDLE); end
    cyc();
    total++;
    if (stall_cnt !== 32'd3 || flush_cnt !== 16'd0) begin
      bad++; $display("FAIL mw_cnt got=%0d/%0d want=3/0", stall_cnt, flush_cnt);
    end
    @(negedge clk);
    total++;
    if (ctl !== C_IDLE) begin bad++; $display("FAIL mw_single got=%b want=%b", ctl, C_IDLE); end
    cyc();
    hz.i_mem_req = 0; hz.i_dmem_ready = 0;
    @(negedge clk);
    total++;
    if (ctl !== C_IDLE || stall_cnt !== 32'd3) begin
      bad++; $display("FAIL mw_run got=%b/%0d want=%b/3", ctl, stall_cnt, C_IDLE);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    hz.i_mem_req = 1; hz.i_dmem_ready = 0;
    repeat (254) cyc();
    total++;
    if (tmo !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b want=0", tmo); end
    cyc();
    total++;
    if (tmo !== 1'b1 || stall_cnt !== 32'd255) begin
      bad++; $display("FAIL tmo_set got=%b/%0d want=1/255", tmo, stall_cnt);
    end
    @(negedge clk);
    total++;
    if (ctl !== C_MW) begin bad++; $display("FAIL tmo_hold got=%b want=%b", ctl, C_MW); end
    hz.i_dmem_ready = 1;
    cyc();
    clear_in();
    cyc();
    @(negedge clk);
    total++;
    if (tmo !== 1'b1 || ctl !== C_IDLE) begin
      bad++; $display("FAIL tmo_sticky got=%b/%b want=1/%b", tmo, ctl, C_IDLE);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++;
    if (tmo !== 1'b0) begin bad++; $display("FAIL tmo_clr got=%b want=0", tmo); end
  endtask

  task automatic test_reset_mwait();
    do_reset();
    hz.i_mem_req = 1; hz.i_dmem_ready = 0; hz.i_dec_br_taken = 1;
    cyc();
    cyc();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (ctl !== C_IDLE) begin bad++; $display("FAIL rstmw_ctl got=%b want=%b", ctl, C_IDLE); end
    cyc();
    rst = 1'b0;
    hz.i_mem_req = 0; hz.i_dec_br_taken = 0;
    @(negedge clk);
    total++;
    if (ctl !== C_IDLE || stall_cnt !== 32'd0 || flush_cnt !== 16'd0 || tmo !== 1'b0) begin
      bad++;
      $display("FAIL rstmw_after got=%b/%0d/%0d/%b want=%b/0/0/0",
               ctl, stall_cnt, flush_cnt, tmo, C_IDLE);
    end
  endtask

  task automatic test_random();
    bit m_busy;
    int unsigned m_stall, m_flush;
    logic [10:0] want;
    int errs;
    do_reset();
    m_busy = 0; m_stall = 0; m_flush = 0; errs = 0;
    for (int i = 0; i < 400; i++) begin
      hz.i_dec_rs = 5'($urandom_range(0, 3));
      hz.i_dec_rt = 5'($urandom_range(0, 3));
      hz.i_dec_rs_use = 1'($urandom);
      hz.i_dec_rt_use = 1'($urandom);
      hz.i_dec_br_taken = ($urandom_range(0, 3) == 0);
      hz.i_exe_wra = 5'($urandom_range(0, 3));
      hz.i_exe_regwe = 1'($urandom);
      hz.i_exe_isload = 1'($urandom);
      hz.i_mem_wra = 5'($urandom_range(0, 3));
      hz.i_mem_regwe = 1'($urandom);
      hz.i_mem_req = ($urandom_range(0, 3) == 0);
      hz.i_dmem_ready = 1'($urandom);
      @(negedge clk);
      want = model_ctl(m_busy);
      total++;
      if (ctl !== want && errs < 10) begin
        bad++; errs++; $display("FAIL rnd_ctl%0d got=%b want=%b", i, ctl, want);
      end else if (ctl !== want) begin
        bad++;
      end
      if (want[10]) m_stall++;
      if (want[4]) m_flush++;
      m_busy = want[7];
      cyc();
      total++;
      if (stall_cnt !== m_stall || flush_cnt !== 16'(m_flush) || tmo !== 1'b0) begin
        bad++;
        if (errs < 10) begin
          errs++;
          $display("FAIL rnd_cnt%0d got=%0d/%0d/%b want=%0d/%0d/0",
                   i, stall_cnt, flush_cnt, tmo, m_stall, m_flush);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mwait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
